// File: rtl/hqm_aw_sram_pg_seq.sv
// Power-gated banked single-port SRAM wrapper: staggered bank wake, ready/valid access, RD_LAT pipe.
// Define HQM_AW_SRAM_PG_PAR_EN to add per-bank even parity storage and the par_err strobe.
module hqm_aw_sram_pg_seq #(
    parameter int unsigned DEPTH    = 2048,
    parameter int unsigned DWIDTH   = 139,
    parameter int unsigned BANK_W   = 70,
    parameter int unsigned WAKE_DLY = 4,
    parameter int unsigned RD_LAT   = 1,
    localparam int unsigned NUM_BANKS = (DWIDTH + BANK_W - 1) / BANK_W,
    localparam int unsigned AWIDTH    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clk_rst_n,
    input  logic              pwr_on_req,
    output logic              pwr_on_ack,
    output logic              pwr_enable_b_out,
    input  logic              pgcb_isol_en,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rdata_v,
    output logic [DWIDTH-1:0] rdata
`ifdef HQM_AW_SRAM_PG_PAR_EN
    ,
    output logic              par_err
`endif
);

`ifdef HQM_AW_SRAM_PG_PAR_EN
    localparam int unsigned PW = 1;
`else
    localparam int unsigned PW = 0;
`endif
    localparam int unsigned SW       = BANK_W + PW;
    localparam int unsigned PADW     = NUM_BANKS * BANK_W;
    localparam int unsigned WAKE_TOT = NUM_BANKS * WAKE_DLY;
    localparam int unsigned WCW      = $clog2(WAKE_TOT + 1);

    typedef enum logic [1:0] {StOff, StWake, StOn, StDrain} state_e;

    state_e               state_q, state_d;
    logic [WCW-1:0]       wcnt_q, wcnt_d;
    logic [NUM_BANKS-1:0] enb_q, enb_d;
    logic                 pipe_busy;

    // ---------------- power sequencer ----------------
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            StOff: begin
                if (pwr_on_req) begin
                    state_d = StWake;
                    wcnt_d  = '0;
                end
            end
            StWake: begin
                if (!pwr_on_req) begin
                    state_d = StOff;
                end else if (wcnt_q == WCW'(WAKE_TOT - 1)) begin
                    state_d = StOn;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            StOn: begin
                if (!pwr_on_req) state_d = StDrain;
            end
            StDrain: begin
                if (!pipe_busy) state_d = StOff;
            end
            default: state_d = StOff;
        endcase
    end

    // Enables are registered from next-state so each switch changes cleanly once per edge.
    always_comb begin
        enb_d = '1;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (state_d == StOn || state_d == StDrain) begin
                enb_d[i] = 1'b0;
            end else if (state_d == StWake && 32'(wcnt_d) >= i * WAKE_DLY) begin
                enb_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge clk_rst_n) begin
        if (!clk_rst_n) begin
            state_q <= StOff;
            wcnt_q  <= '0;
            enb_q   <= '1;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            enb_q   <= enb_d;
        end
    end

    assign pwr_on_ack       = (state_q == StOn);
    assign req_ready        = (state_q == StOn) & ~pgcb_isol_en;
    assign pwr_enable_b_out = enb_q[NUM_BANKS-1];

    // ---------------- array ----------------
    logic                      acc, in_range, wr, rd, rd_hit;
    logic [AWIDTH-1:0]         acc_addr;
    logic [NUM_BANKS*SW-1:0]   mem [DEPTH];
    logic [NUM_BANKS*SW-1:0]   wword, rword;
    logic [PADW-1:0]           wpad, rpad;
    logic [DEPTH-1:0]          wvld_q;
    logic [DWIDTH-1:0]         rd_data;
    logic [DWIDTH+PW-1:0]      rd_pkt, ret_pkt, out_q;
    logic                      ret_v, rv_q;
`ifdef HQM_AW_SRAM_PG_PAR_EN
    logic                      rd_perr;
`endif

    assign acc      = req_valid & req_ready;
    assign in_range = 32'(req_addr) < DEPTH;
    assign acc_addr = in_range ? req_addr : '0;
    assign wr       = acc & req_we & in_range;
    assign rd       = acc & ~req_we;
    assign wpad     = PADW'(req_wdata);
    assign rword    = mem[acc_addr];

    always_comb begin
        wword = '0;
        rpad  = '0;
`ifdef HQM_AW_SRAM_PG_PAR_EN
        rd_perr = 1'b0;
`endif
        for (int i = 0; i < NUM_BANKS; i++) begin
            wword[i*SW +: BANK_W]  = wpad[i*BANK_W +: BANK_W];
            rpad[i*BANK_W +: BANK_W] = rword[i*SW +: BANK_W];
`ifdef HQM_AW_SRAM_PG_PAR_EN
            wword[i*SW + BANK_W] = ^wpad[i*BANK_W +: BANK_W];
            rd_perr              = rd_perr | (^rword[i*SW +: SW]);
`endif
        end
    end

    if (PADW > DWIDTH) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^rpad[PADW-1:DWIDTH];
    end

    // Words never written since the last power-up read as zero.
    assign rd_hit  = in_range & wvld_q[acc_addr];
    assign rd_data = rd_hit ? rpad[DWIDTH-1:0] : '0;
`ifdef HQM_AW_SRAM_PG_PAR_EN
    assign rd_pkt = {rd_hit & rd_perr, rd_data};
`else
    assign rd_pkt = rd_data;
`endif

    always_ff @(posedge clk) begin
        if (wr) mem[acc_addr] <= wword;
    end

    always_ff @(posedge clk or negedge clk_rst_n) begin
        if (!clk_rst_n) begin
            wvld_q <= '0;
        end else if (state_q != StOff && state_d == StOff) begin
            wvld_q <= '0;
        end else if (wr) begin
            wvld_q[acc_addr] <= 1'b1;
        end
    end

    // ---------------- read pipe ----------------
    if (RD_LAT > 1) begin : g_lat2
        logic                 s1_v_q;
        logic [DWIDTH+PW-1:0] s1_pkt_q;
        always_ff @(posedge clk or negedge clk_rst_n) begin
            if (!clk_rst_n) begin
                s1_v_q   <= 1'b0;
                s1_pkt_q <= '0;
            end else begin
                s1_v_q <= rd;
                if (rd) s1_pkt_q <= rd_pkt;
            end
        end
        assign ret_v     = s1_v_q;
        assign ret_pkt   = s1_pkt_q;
        assign pipe_busy = s1_v_q;
    end else begin : g_lat1
        assign ret_v     = rd;
        assign ret_pkt   = rd_pkt;
        assign pipe_busy = 1'b0;
    end

    always_ff @(posedge clk or negedge clk_rst_n) begin
        if (!clk_rst_n) begin
            rv_q  <= 1'b0;
            out_q <= '0;
        end else begin
            rv_q <= ret_v;
            if (ret_v) out_q <= ret_pkt;
        end
    end

    assign rdata_v = rv_q;
    assign rdata   = pgcb_isol_en ? '0 : out_q[DWIDTH-1:0];
`ifdef HQM_AW_SRAM_PG_PAR_EN
    assign par_err = rv_q & out_q[DWIDTH];
`endif

endmodule

// File: tb/tb_hqm_aw_sram_pg_seq.sv
// Bench: default DUT (u_a) and DEPTH=2000/RD_LAT=2 DUT (u_b) share stimulus; reads are scoreboarded.
module tb_hqm_aw_sram_pg_seq;
    localparam int DW = 139;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pwr_on_req = 1'b0, isol = 1'b0, req_valid = 1'b0, req_we = 1'b0;
    logic [10:0]   req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          ack_a, enb_a, ready_a, rv_a, ack_b, enb_b, ready_b, rv_b;
    logic [DW-1:0] rdata_a, rdata_b;
`ifdef HQM_AW_SRAM_PG_PAR_EN
    logic          par_a, par_b;
`endif

    hqm_aw_sram_pg_seq u_a (
        .clk(clk), .clk_rst_n(rst_n), .pwr_on_req(pwr_on_req), .pwr_on_ack(ack_a),
        .pwr_enable_b_out(enb_a), .pgcb_isol_en(isol), .req_valid(req_valid),
        .req_ready(ready_a), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata_v(rv_a), .rdata(rdata_a)
`ifdef HQM_AW_SRAM_PG_PAR_EN
        , .par_err(par_a)
`endif
    );

    hqm_aw_sram_pg_seq #(.DEPTH(2000), .RD_LAT(2)) u_b (
        .clk(clk), .clk_rst_n(rst_n), .pwr_on_req(pwr_on_req), .pwr_on_ack(ack_b),
        .pwr_enable_b_out(enb_b), .pgcb_isol_en(isol), .req_valid(req_valid),
        .req_ready(ready_b), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata_v(rv_b), .rdata(rdata_b)
`ifdef HQM_AW_SRAM_PG_PAR_EN
        , .par_err(par_b)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] d;
        int            due;
        bit            pe;
    } exp_t;

    exp_t          qa[$], qb[$];
    exp_t          ea, eb;
    logic [DW-1:0] ma [int];
    logic [DW-1:0] mb [int];
    int            n_cmp = 0, n_mis = 0;
    logic [DW-1:0] ones, p0, p1;
    logic [159:0]  rnd;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input bit we, input logic [10:0] a, input logic [DW-1:0] d, input bit pe);
        exp_t e;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        chk("req_ready", ready_a, 1);
        if (we) begin
            ma[int'(a)] = d;
            if (a < 2000) mb[int'(a)] = d;
        end else begin
            e.d = ma.exists(int'(a)) ? ma[int'(a)] : '0;
            e.due = cyc + 1;
            e.pe = pe;
            qa.push_back(e);
            e.d = (a < 2000 && mb.exists(int'(a))) ? mb[int'(a)] : '0;
            e.due = cyc + 2;
            e.pe = 1'b0;
            qb.push_back(e);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_off();
        for (int i = 0; i < 8 && enb_a !== 1'b1; i++) tick();
        chk("reached_off", enb_a, 1);
        ma.delete();
        mb.delete();
    endtask

    task automatic wait_ack();
        int n = 0;
        while (ack_a !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("wake_cycles", n, 9);
    endtask

    always @(negedge clk) begin
        if (rv_a === 1'b1) begin
            if (qa.size() == 0) chk("a_unexpected_rdata_v", 1, 0);
            else begin
                ea = qa.pop_front();
                chk("a_rdata", rdata_a, ea.d);
                chk("a_latency", cyc, ea.due);
`ifdef HQM_AW_SRAM_PG_PAR_EN
                chk("a_par_err", par_a, ea.pe);
`endif
            end
        end
        if (rv_b === 1'b1) begin
            if (qb.size() == 0) chk("b_unexpected_rdata_v", 1, 0);
            else begin
                eb = qb.pop_front();
                chk("b_rdata", rdata_b, eb.d);
                chk("b_latency", cyc, eb.due);
`ifdef HQM_AW_SRAM_PG_PAR_EN
                chk("b_par_err", par_b, eb.pe);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ones = '1;
        p0   = {11'h5a5, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210};
        rnd  = {$urandom, $urandom, $urandom, $urandom, $urandom};
        p1   = rnd[DW-1:0];

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", ack_a, 0);
        chk("rst_enb_out", enb_a, 1);
        chk("rst_ready", ready_a, 0);
        chk("rst_rdata_v", rv_a, 0);
        chk("rst_rdata", rdata_a, 0);
        chk("rst_bank_enb", u_a.enb_q, 2'b11);
        chk("rst_b_ack", ack_b, 0);
        rst_n = 1'b1;
        tick();

        // Staggered wake: bank0 at cycle 1, last bank at cycle 5, ack at cycle 9.
        pwr_on_req = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            chk("wake_bank0_enb", u_a.enb_q[0], 0);
            chk("wake_enb_out", enb_a, (c >= 5) ? 0 : 1);
            chk("wake_ack", ack_a, (c >= 9) ? 1 : 0);
            chk("wake_ready", ready_a, (c >= 9) ? 1 : 0);
            chk("wake_b_ack", ack_b, (c >= 9) ? 1 : 0);
        end

        acc(1'b1, 11'h7ff, ones, 1'b0);
        acc(1'b1, 11'h000, p0, 1'b0);
        acc(1'b1, 11'h010, p1, 1'b0);
        acc(1'b0, 11'h010, '0, 1'b0);
        acc(1'b0, 11'h7ff, '0, 1'b0);
        acc(1'b0, 11'h000, '0, 1'b0);
        acc(1'b0, 11'h010, '0, 1'b0);
        repeat (3) tick();
        chk("on_qa_empty", qa.size(), 0);
        chk("on_qb_empty", qb.size(), 0);

        isol = 1'b1;
        #1;
        chk("isol_rdata_a", rdata_a, 0);
        chk("isol_rdata_b", rdata_b, 0);
        chk("isol_ready", ready_a, 0);
        isol = 1'b0;
        #1;
        chk("unisol_rdata_a", rdata_a, p1);
        chk("unisol_ready", ready_a, 1);

`ifdef HQM_AW_SRAM_PG_PAR_EN
        acc(1'b1, 11'h001, 139'h1, 1'b0);
        u_a.mem[1][0] = ~u_a.mem[1][0];
        ma[1] = '0;
        acc(1'b0, 11'h001, '0, 1'b1);
        acc(1'b0, 11'h010, '0, 1'b0);
        repeat (3) tick();
`endif

        // Read in flight while power request drops.
        acc(1'b0, 11'h7ff, '0, 1'b0);
        pwr_on_req = 1'b0;
        tick();
        chk("drain_ready", ready_a, 0);
        chk("drain_ack", ack_a, 0);
        wait_off();
        repeat (2) tick();
        chk("drain_qa_empty", qa.size(), 0);
        chk("drain_qb_empty", qb.size(), 0);

        pwr_on_req = 1'b1;
        wait_ack();
        acc(1'b0, 11'h7ff, '0, 1'b0);
        acc(1'b0, 11'h000, '0, 1'b0);
        repeat (3) tick();
        chk("rewake_qa_empty", qa.size(), 0);
        pwr_on_req = 1'b0;
        tick();
        wait_off();

        // Abort at wake cycle 3.
        pwr_on_req = 1'b1;
        repeat (3) begin
            tick();
            chk("abort_ack", ack_a, 0);
        end
        pwr_on_req = 1'b0;
        tick();
        chk("abort_bank_enb", u_a.enb_q, 2'b11);
        chk("abort_enb_out", enb_a, 1);
        chk("abort_ack_after", ack_a, 0);
        repeat (2) tick();

        // Asynchronous reset with reads in flight discards them.
        pwr_on_req = 1'b1;
        wait_ack();
        acc(1'b0, 11'h010, '0, 1'b0);
        rst_n = 1'b0;
        pwr_on_req = 1'b0;
        qa.delete();
        qb.delete();
        #1;
        chk("arst_ack", ack_a, 0);
        chk("arst_enb_out", enb_a, 1);
        chk("arst_rdata_v_a", rv_a, 0);
        chk("arst_rdata_a", rdata_a, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("end_qa_empty", qa.size(), 0);
        chk("end_qb_empty", qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
